// File: rtl/status_mwr_tx_pkg.sv
// Shared constants, FSM encoding and helpers for the TX memory-write engines.
package status_mwr_tx_pkg;

  // fmt/type byte of a posted memory write, 3DW and 4DW header
  localparam logic [7:0] MEM_WR32_FMT_TYPE = 8'h40;
  localparam logic [7:0] MEM_WR64_FMT_TYPE = 8'h60;
  localparam logic [7:0] MWR32_FMT_TYPE    = MEM_WR32_FMT_TYPE;
  localparam logic [7:0] MWR64_FMT_TYPE    = MEM_WR64_FMT_TYPE;

  localparam logic [9:0] STATUS_LEN_DW = 10'd2;
  localparam logic [7:0] MWR_TAG       = 8'h00;
  localparam logic [3:0] MWR_BE_ALL    = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StGrant,
    StB0,
    StB1,
    StB2,
    StDone
  } mwr_state_e;

  // Host payload is little-endian per DW; TRN carries DWs big-endian.
  function automatic logic [31:0] dw_bswap(input logic [31:0] dw);
    return {dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
  endfunction

endpackage

// File: rtl/status_mwr_tx_hdr_gen.sv
// Combinational MWr header builder (DW0..DW3), reusable by other TX engines.
module tlp_mwr_hdr_gen
  import status_mwr_tx_pkg::*;
(
  input  logic        is_64,
  input  logic [15:0] completer_id,
  input  logic [63:2] addr,
  input  logic [9:0]  length,
  output logic [31:0] dw0,
  output logic [31:0] dw1,
  output logic [31:0] dw2,
  output logic [31:0] dw3
);

  // TC/TD/EP/attr all zero; dw3 only meaningful for the 4DW form
  always_comb begin
    dw0 = {(is_64 ? MWR64_FMT_TYPE : MWR32_FMT_TYPE), 8'h00, 6'b000000, length};
    dw1 = {completer_id, MWR_TAG, MWR_BE_ALL, MWR_BE_ALL};
    dw2 = is_64 ? addr[63:32] : {addr[31:2], 2'b00};
    dw3 = is_64 ? {addr[31:2], 2'b00} : 32'h0000_0000;
  end

endmodule

// File: rtl/status_mwr_tx.sv
// Posts a 2-DW status word into host memory as a PCIe MWr TLP on TRN TX.
module status_mwr_tx
  import status_mwr_tx_pkg::*;
#(
  parameter int unsigned POSTED_BUF_BIT = 1,
  parameter bit          FORCE_64BIT    = 1'b0
) (
  input  logic        trn_clk,
  input  logic        reset,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  input  logic        trn_tdst_rdy_n,
  input  logic [3:0]  trn_tbuf_av,
  input  logic [15:0] cfg_completer_id,
  input  logic        my_turn,
  output logic        req_ep,
  output logic        driving_interface,
  input  logic        send_status,
  input  logic [63:0] host_addr,
  input  logic [63:0] status_data,
  output logic        status_sent,
  output logic        busy
);

  mwr_state_e  state_q, state_d;
  logic        pend_q, pend_d;
  logic [63:2] pend_addr_q, pend_addr_d;
  logic [63:0] pend_data_q, pend_data_d;
  logic [63:2] work_addr_q, work_addr_d;
  logic [63:0] work_data_q, work_data_d;
  logic [63:0] td_q, td_d;
  logic [7:0]  trem_n_q, trem_n_d;
  logic        sof_n_q, sof_n_d;
  logic        eof_n_q, eof_n_d;
  logic        src_rdy_n_q, src_rdy_n_d;
  logic        req_q, req_d;
  logic        drv_q, drv_d;
  logic        sent_q, sent_d;

  logic        is_64;
  logic [31:0] dw0, dw1, dw2, dw3;
  logic [63:0] beat0, beat1, beat2;
  logic        unused_addr_lsb;

  // DW alignment makes the two address LSBs meaningless
  assign unused_addr_lsb = ^host_addr[1:0];

  assign is_64 = FORCE_64BIT || (work_addr_q[63:32] != 32'h0000_0000);

  tlp_mwr_hdr_gen u_hdr_gen (
    .is_64        (is_64),
    .completer_id (cfg_completer_id),
    .addr         (work_addr_q),
    .length       (STATUS_LEN_DW),
    .dw0          (dw0),
    .dw1          (dw1),
    .dw2          (dw2),
    .dw3          (dw3)
  );

  // Beat payloads: 3DW packs D0 next to the address, 4DW pushes both data DWs to beat2
  always_comb begin
    beat0 = {dw0, dw1};
    beat1 = is_64 ? {dw2, dw3} : {dw2, dw_bswap(work_data_q[31:0])};
    beat2 = is_64 ? {dw_bswap(work_data_q[31:0]), dw_bswap(work_data_q[63:32])}
                  : {dw_bswap(work_data_q[63:32]), 32'h0000_0000};
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    work_addr_d = work_addr_q;
    work_data_d = work_data_q;
    td_d        = td_q;
    trem_n_d    = trem_n_q;
    sof_n_d     = sof_n_q;
    eof_n_d     = eof_n_q;
    src_rdy_n_d = src_rdy_n_q;
    req_d       = req_q;
    drv_d       = drv_q;
    sent_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          work_addr_d = pend_addr_q;
          work_data_d = pend_data_q;
          pend_d      = 1'b0;
          req_d       = 1'b1;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (my_turn) begin
          req_d   = 1'b0;
          drv_d   = 1'b1;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (trn_tbuf_av[POSTED_BUF_BIT]) begin
          td_d        = beat0;
          trem_n_d    = 8'h00;
          sof_n_d     = 1'b0;
          src_rdy_n_d = 1'b0;
          state_d     = StB0;
        end
      end
      StB0: begin
        if (!trn_tdst_rdy_n) begin
          td_d    = beat1;
          sof_n_d = 1'b1;
          state_d = StB1;
        end
      end
      StB1: begin
        if (!trn_tdst_rdy_n) begin
          td_d     = beat2;
          trem_n_d = is_64 ? 8'h00 : 8'h0F;
          eof_n_d  = 1'b0;
          state_d  = StB2;
        end
      end
      StB2: begin
        if (!trn_tdst_rdy_n) begin
          td_d        = '0;
          trem_n_d    = 8'h00;
          eof_n_d     = 1'b1;
          src_rdy_n_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        drv_d   = 1'b0;
        sent_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Capture after the IDLE hand-off so a same-cycle request re-arms the slot (last wins)
    if (send_status) begin
      pend_d      = 1'b1;
      pend_addr_d = host_addr[63:2];
      pend_data_d = status_data;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      work_addr_q <= '0;
      work_data_q <= '0;
      td_q        <= '0;
      trem_n_q    <= 8'h00;
      sof_n_q     <= 1'b1;
      eof_n_q     <= 1'b1;
      src_rdy_n_q <= 1'b1;
      req_q       <= 1'b0;
      drv_q       <= 1'b0;
      sent_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      work_addr_q <= work_addr_d;
      work_data_q <= work_data_d;
      td_q        <= td_d;
      trem_n_q    <= trem_n_d;
      sof_n_q     <= sof_n_d;
      eof_n_q     <= eof_n_d;
      src_rdy_n_q <= src_rdy_n_d;
      req_q       <= req_d;
      drv_q       <= drv_d;
      sent_q      <= sent_d;
    end
  end

  assign trn_td            = td_q;
  assign trn_trem_n        = trem_n_q;
  assign trn_tsof_n        = sof_n_q;
  assign trn_teof_n        = eof_n_q;
  assign trn_tsrc_rdy_n    = src_rdy_n_q;
  assign req_ep            = req_q;
  assign driving_interface = drv_q;
  assign status_sent       = sent_q;
  assign busy              = (state_q != StIdle) || pend_q;

endmodule
